// File: rtl/regbank_pkg.sv
// regbank_pkg: shared constants and types for the register bank
// Provides default widths (DATA_W_DEF, ADDR_W_DEF) and the address/data
// word types used at the default configuration.
package regbank_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;
endpackage

// File: rtl/regbank_read_port.sv
// regbank_read_port: one combinational read port of the register bank
// Ports: regs (flattened storage array), rAddr -> rdData, plus the write
// port signals (reset, write, wrAddr, wrData) used for forwarding.
// Build option: REGBANK_WRITE_BYPASS_EN enables same-cycle write-through.
module regbank_read_port
    import regbank_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int HARDWIRE_ZERO = 1
) (
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
    input  logic                               reset,
    input  logic                               write,
    input  logic [ADDR_W-1:0]                  wrAddr,
    input  logic [DATA_W-1:0]                  wrData,
    input  logic [ADDR_W-1:0]                  rAddr,
    output logic [DATA_W-1:0]                  rdData
);
`ifdef REGBANK_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    logic isZero;
    logic fwdHit;
    assign isZero = (HARDWIRE_ZERO != 0) && (rAddr == '0);
    assign fwdHit = BYPASS && write && !reset && (rAddr == wrAddr);
    // Zero-register rule outranks forwarding so address 0 never leaks wrData.
    assign rdData = isZero ? '0 : fwdHit ? wrData : regs[rAddr];
endmodule

// File: rtl/register_bank.sv
// register_bank: 2**ADDR_W x DATA_W register file, 1 write / 2 read ports
// Ports: clk, reset (async, active-high, clears all registers),
// write/wrAddr/wrData (synchronous write), rAddrA -> rdDataA and
// rAddrB -> rdDataB (combinational reads).
// Build option: REGBANK_WRITE_BYPASS_EN (handled inside regbank_read_port).
module register_bank
    import regbank_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int HARDWIRE_ZERO = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rAddrA,
    output logic [DATA_W-1:0] rdDataA,
    input  logic [ADDR_W-1:0] rAddrB,
    output logic [DATA_W-1:0] rdDataB
);
    logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs;
    logic                               wrEn;
    // Writes to the hardwired zero register are dropped at the source.
    assign wrEn = write && !((HARDWIRE_ZERO != 0) && (wrAddr == '0));
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            regs <= '0;
        else if (wrEn)
            regs[wrAddr] <= wrData;
    end
    regbank_read_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .HARDWIRE_ZERO(HARDWIRE_ZERO)
    ) portA (
        .regs(regs), .reset(reset), .write(write), .wrAddr(wrAddr),
        .wrData(wrData), .rAddr(rAddrA), .rdData(rdDataA)
    );
    regbank_read_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .HARDWIRE_ZERO(HARDWIRE_ZERO)
    ) portB (
        .regs(regs), .reset(reset), .write(write), .wrAddr(wrAddr),
        .wrData(wrData), .rAddr(rAddrB), .rdData(rdDataB)
    );
endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: randomized self-checking bench for register_bank
module tb_register_bank;
`ifdef REGBANK_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write = 1'b0;
    logic [4:0]  wrAddr = '0;
    logic [31:0] wrData = '0;
    logic [4:0]  rAddrA = '0;
    logic [4:0]  rAddrB = '0;
    logic [31:0] rdDataA;
    logic [31:0] rdDataB;
    logic [31:0] model [32];
    int checks = 0;
    int errors = 0;

    register_bank dut (
        .clk(clk), .reset(reset), .write(write), .wrAddr(wrAddr),
        .wrData(wrData), .rAddrA(rAddrA), .rdDataA(rdDataA),
        .rAddrB(rAddrB), .rdDataB(rdDataB)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] expRead(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (reset) return 32'd0;
        if (BYP && write && a == wrAddr) return wrData;
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        write = 1'b1; wrAddr = a; wrData = d;
        @(negedge clk);
        write = 1'b0;
        if (a != 0) model[a] = d;
    endtask

    task automatic test_reset();
        clear_model();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rAddrA = 5'd6; rAddrB = 5'd0;
        #1;
        checks++;
        if (rdDataA !== 32'd0) begin errors++; $display("FAIL reset_a got %h exp %h", rdDataA, 32'd0); end
        checks++;
        if (rdDataB !== 32'd0) begin errors++; $display("FAIL reset_b got %h exp %h", rdDataB, 32'd0); end
    endtask

    task automatic test_write();
        do_write(5'd3, 32'd666);
        rAddrA = 5'd3; #1;
        checks++;
        if (rdDataA !== 32'd666) begin errors++; $display("FAIL write_a3 got %h exp %h", rdDataA, 32'd666); end
        rAddrA = 5'd6; #1;
        checks++;
        if (rdDataA !== 32'd0) begin errors++; $display("FAIL write_a6 got %h exp %h", rdDataA, 32'd0); end
    endtask

    task automatic test_no_write();
        @(negedge clk);
        write = 1'b0; wrAddr = 5'd5; wrData = 32'd123;
        repeat (3) @(negedge clk);
        rAddrB = 5'd5; #1;
        checks++;
        if (rdDataB !== 32'd0) begin errors++; $display("FAIL nowrite_b5 got %h exp %h", rdDataB, 32'd0); end
    endtask

    task automatic test_zero_reg();
        do_write(5'd0, 32'hDEADBEEF);
        rAddrA = 5'd0; rAddrB = 5'd0; #1;
        checks++;
        if (rdDataA !== 32'd0) begin errors++; $display("FAIL zero_a got %h exp %h", rdDataA, 32'd0); end
        checks++;
        if (rdDataB !== 32'd0) begin errors++; $display("FAIL zero_b got %h exp %h", rdDataB, 32'd0); end
        do_write(5'd31, 32'd7);
        do_write(5'd30, 32'd9);
        rAddrA = 5'd31; rAddrB = 5'd30; #1;
        checks++;
        if (rdDataA !== 32'd7) begin errors++; $display("FAIL dual_a31 got %h exp %h", rdDataA, 32'd7); end
        checks++;
        if (rdDataB !== 32'd9) begin errors++; $display("FAIL dual_b30 got %h exp %h", rdDataB, 32'd9); end
    endtask

    task automatic test_async_reset();
        do_write(5'd4, 32'h55);
        rAddrA = 5'd4; rAddrB = 5'd31; #1;
        checks++;
        if (rdDataA !== 32'h55) begin errors++; $display("FAIL pre_rst_a4 got %h exp %h", rdDataA, 32'h55); end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (rdDataA !== 32'd0) begin errors++; $display("FAIL async_rst_a4 got %h exp %h", rdDataA, 32'd0); end
        checks++;
        if (rdDataB !== 32'd0) begin errors++; $display("FAIL async_rst_b31 got %h exp %h", rdDataB, 32'd0); end
        clear_model();
        @(negedge clk);
        write = 1'b1; wrAddr = 5'd4; wrData = 32'h77;
        repeat (2) @(negedge clk);
        write = 1'b0; reset = 1'b0;
        #1;
        checks++;
        if (rdDataA !== 32'd0) begin errors++; $display("FAIL rst_write_a4 got %h exp %h", rdDataA, 32'd0); end
    endtask

    task automatic test_same_addr();
        @(negedge clk);
        rAddrA = 5'd8; rAddrB = 5'd8; wrAddr = 5'd8; wrData = 32'd42; write = 1'b1;
        #1;
        checks++;
        if (rdDataA !== (BYP ? 32'd42 : 32'd0)) begin errors++; $display("FAIL same_pre_a got %h exp %h", rdDataA, BYP ? 32'd42 : 32'd0); end
        checks++;
        if (rdDataB !== (BYP ? 32'd42 : 32'd0)) begin errors++; $display("FAIL same_pre_b got %h exp %h", rdDataB, BYP ? 32'd42 : 32'd0); end
        @(negedge clk);
        write = 1'b0; model[8] = 32'd42;
        #1;
        checks++;
        if (rdDataA !== 32'd42) begin errors++; $display("FAIL same_post_a got %h exp %h", rdDataA, 32'd42); end
        checks++;
        if (rdDataB !== 32'd42) begin errors++; $display("FAIL same_post_b got %h exp %h", rdDataB, 32'd42); end
    endtask

    task automatic test_random();
        logic [31:0] ea, eb;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            write  = ($urandom_range(0, 2) != 0);
            wrAddr = 5'($urandom_range(0, 31));
            wrData = $urandom;
            rAddrA = ($urandom_range(0, 3) == 0) ? wrAddr : 5'($urandom_range(0, 31));
            rAddrB = ($urandom_range(0, 3) == 0) ? wrAddr : 5'($urandom_range(0, 31));
            #1;
            ea = expRead(rAddrA);
            eb = expRead(rAddrB);
            checks++;
            if (rdDataA !== ea) begin errors++; $display("FAIL rand_a[%0d] addr %0d got %h exp %h", n, rAddrA, rdDataA, ea); end
            checks++;
            if (rdDataB !== eb) begin errors++; $display("FAIL rand_b[%0d] addr %0d got %h exp %h", n, rAddrB, rdDataB, eb); end
            @(posedge clk);
            if (write && wrAddr != 0) model[wrAddr] = wrData;
        end
        @(negedge clk);
        write = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rAddrA = 5'(i); rAddrB = 5'(31 - i);
            #1;
            checks++;
            if (rdDataA !== expRead(rAddrA)) begin errors++; $display("FAIL sweep_a addr %0d got %h exp %h", i, rdDataA, expRead(rAddrA)); end
            checks++;
            if (rdDataB !== expRead(rAddrB)) begin errors++; $display("FAIL sweep_b addr %0d got %h exp %h", 31 - i, rdDataB, expRead(rAddrB)); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_no_write();
        test_zero_reg();
        test_async_reset();
        test_same_addr();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
